uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 114 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NREQ byte producers; frames are timed locally.
// Optional idle gap after each frame is enabled by defining UART_ARB_GAP_EN.
module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned FRAME_BITS   = 11,
    parameter int unsigned GAP_BITS     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [8*NREQ-1:0]         req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic [7:0]                tx_data,
    output logic                      tx_send,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);

    localparam int unsigned IDW       = $clog2(NREQ);
    localparam int unsigned FRAME_CYC = FRAME_BITS * CLKS_PER_BIT;
    localparam int unsigned GAP_CYC   = GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned CNTW      = $clog2(FRAME_CYC + GAP_CYC);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWait
`ifdef UART_ARB_GAP_EN
        , StGap
`endif
    } state_e;

    state_e          state_q;
    logic [CNTW-1:0] cnt_q;
    logic [IDW-1:0]  ptr_q;

    logic [IDW-1:0]  win;
    logic [IDW-1:0]  cand;
    logic            any_valid;

    // First valid requester after the pointer, wrapping modulo NREQ.
    always_comb begin
        win       = ptr_q;
        cand      = ptr_q;
        any_valid = 1'b0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = IDW'((int'(ptr_q) + k) % int'(NREQ));
            if (!any_valid && req_valid[cand]) begin
                win       = cand;
                any_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ptr_q     <= IDW'(NREQ - 1);
            req_ready <= '0;
            tx_data   <= '0;
            tx_send   <= 1'b0;
            grant_id  <= IDW'(NREQ - 1);
            busy      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        // Only the winner's byte is selected, so junk on other lanes never leaks.
                        tx_data   <= req_data[8*win +: 8];
                        grant_id  <= win;
                        ptr_q     <= win;
                        req_ready <= NREQ'(1) << win;
                        tx_send   <= 1'b1;
                        busy      <= 1'b1;
                        state_q   <= StSend;
                    end
                end
                StSend: begin
                    req_ready <= '0;
                    tx_send   <= 1'b0;
                    cnt_q     <= CNTW'(FRAME_CYC - 1);
                    state_q   <= StWait;
                end
                StWait: begin
                    if (cnt_q == '0) begin
`ifdef UART_ARB_GAP_EN
                        cnt_q   <= CNTW'(GAP_CYC - 1);
                        state_q <= StGap;
`else
                        busy    <= 1'b0;
                        state_q <= StIdle;
`endif
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
`ifdef UART_ARB_GAP_EN
                StGap: begin
                    if (cnt_q == '0) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized round-robin traffic
// checked against a frame-level model (grant order by rotation, fixed frame spacing).
module tb_uart_tx_arbiter;

    localparam int NREQ      = 4;
    localparam int CPB       = 4;
    localparam int FBITS     = 11;
    localparam int FRAME_CYC = FBITS * CPB;
`ifdef UART_ARB_GAP_EN
    localparam int GAP_CYC   = 2 * CPB;
`else
    localparam int GAP_CYC   = 0;
`endif
    localparam int BUSY_LEN  = 1 + FRAME_CYC + GAP_CYC;
    localparam int PERIOD    = 2 + FRAME_CYC + GAP_CYC;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_data;
    logic              tx_send;
    logic [1:0]        grant_id;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ         (NREQ),
        .CLKS_PER_BIT (CPB),
        .FRAME_BITS   (FBITS),
        .GAP_BITS     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_send   (tx_send),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Advances until tx_send is seen or the budget runs out; n = cycles elapsed.
    task automatic wait_send(input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            tick();
            n++;
            if (tx_send) ok = 1'b1;
        end
    endtask

    // Reference rotation: first valid index after ptr, wrapping.
    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [7:0] lane(input logic [8*NREQ-1:0] d, input int i);
        return d[8*i +: 8];
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        req_data  = $urandom;
        tick();
        tick();
        checks++; if (req_ready !== 4'b0000) begin errors++;
            $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        checks++; if (tx_data !== 8'h00) begin errors++;
            $display("FAIL reset_tx_data got %h want 00", tx_data); end
        checks++; if (tx_send !== 1'b0) begin errors++;
            $display("FAIL reset_tx_send got %b want 0", tx_send); end
        checks++; if (grant_id !== 2'd3) begin errors++;
            $display("FAIL reset_grant_id got %0d want 3", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy got %b want 0", busy); end
        req_valid = '0;
        rst       = 1'b0;
    endtask

    task automatic test_single_byte();
        int n, len, stray, unstable;
        bit ok;
        do_reset();
        req_data       = $urandom;
        req_data[7:0]  = 8'hA5;
        req_valid      = 4'b0001;
        wait_send(4, n, ok);
        checks++; if (!ok || n != 1) begin errors++;
            $display("FAIL a5_latency got %0d ok=%0b want 1", n, ok); end
        checks++; if (req_ready !== 4'b0001) begin errors++;
            $display("FAIL a5_req_ready got %b want 0001", req_ready); end
        checks++; if (tx_data !== 8'hA5) begin errors++;
            $display("FAIL a5_tx_data got %h want a5", tx_data); end
        checks++; if (grant_id !== 2'd0) begin errors++;
            $display("FAIL a5_grant_id got %0d want 0", grant_id); end
        len = 0; stray = 0; unstable = 0;
        while (busy && len < 500) begin
            if (len > 0 && (tx_send || req_ready != '0)) stray++;
            if (tx_data !== 8'hA5 || grant_id !== 2'd0) unstable++;
            len++;
            tick();
        end
        checks++; if (len != BUSY_LEN) begin errors++;
            $display("FAIL a5_busy_len got %0d want %0d", len, BUSY_LEN); end
        checks++; if (stray != 0) begin errors++;
            $display("FAIL a5_stray_strobes got %0d want 0", stray); end
        checks++; if (unstable != 0) begin errors++;
            $display("FAIL a5_output_stable got %0d changes want 0", unstable); end
        wait_send(PERIOD, n, ok);
        checks++; if (!ok || len + n != PERIOD) begin errors++;
            $display("FAIL a5_spacing got %0d want %0d", len + n, PERIOD); end
        checks++; if (grant_id !== 2'd0 || tx_data !== 8'hA5) begin errors++;
            $display("FAIL a5_regrant got id %0d data %h want 0 a5", grant_id, tx_data); end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        int n, ptr, w;
        bit ok;
        do_reset();
        req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
        req_valid = 4'b1111;
        ptr       = NREQ - 1;
        for (int g = 0; g < 5; g++) begin
            wait_send((g == 0) ? 4 : PERIOD + 4, n, ok);
            w = rr_pick(ptr, req_valid);
            checks++; if (!ok || (g > 0 && n != PERIOD)) begin errors++;
                $display("FAIL rr_spacing grant %0d got %0d ok=%0b want %0d", g, n, ok, PERIOD); end
            checks++; if (grant_id !== 2'(w) || tx_data !== lane(req_data, w)
                          || req_ready !== 4'(1 << w)) begin errors++;
                $display("FAIL rr_grant %0d got id %0d data %h rdy %b want id %0d data %h",
                         g, grant_id, tx_data, req_ready, w, lane(req_data, w)); end
            ptr = w;
        end
        req_valid = '0;
    endtask

    task automatic test_single_req2();
        int n;
        bit ok;
        do_reset();
        req_data         = $urandom;
        req_data[23:16]  = 8'h7E;
        req_valid        = 4'b0100;
        for (int g = 0; g < 4; g++) begin
            wait_send((g == 0) ? 4 : PERIOD + 4, n, ok);
            checks++; if (!ok || (g > 0 && n != PERIOD)) begin errors++;
                $display("FAIL req2_spacing grant %0d got %0d want %0d", g, n, PERIOD); end
            checks++; if (grant_id !== 2'd2 || req_ready !== 4'b0100 || tx_data !== 8'h7E)
                begin errors++;
                $display("FAIL req2_grant %0d got id %0d rdy %b data %h want 2 0100 7e",
                         g, grant_id, req_ready, tx_data); end
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_frame();
        int n;
        bit ok;
        do_reset();
        req_data  = $urandom;
        req_valid = 4'b0001;
        wait_send(4, n, ok);
        req_valid = '0;
        for (int i = 0; i < 21; i++) tick();
        rst       = 1'b1;
        req_valid = 4'b0010;
        tick();
        checks++; if (busy !== 1'b0 || tx_send !== 1'b0 || req_ready !== 4'b0000
                      || grant_id !== 2'd3) begin errors++;
            $display("FAIL midrst_outputs got busy %b send %b rdy %b id %0d want 0 0 0000 3",
                     busy, tx_send, req_ready, grant_id); end
        rst = 1'b0;
        wait_send(4, n, ok);
        checks++; if (!ok || n != 1 || grant_id !== 2'd1 || req_ready !== 4'b0010) begin errors++;
            $display("FAIL midrst_regrant got n %0d id %0d rdy %b want 1 1 0010",
                     n, grant_id, req_ready); end
        req_valid = '0;
    endtask

    task automatic test_pointer_midframe();
        int n;
        bit ok;
        do_reset();
        req_data  = $urandom;
        req_valid = 4'b0010;
        wait_send(4, n, ok);
        req_valid = 4'b0000;
        for (int i = 0; i < 5; i++) tick();
        req_valid = 4'b1000;
        for (int i = 0; i < 10; i++) tick();
        req_valid = 4'b1010;
        wait_send(PERIOD + 4, n, ok);
        checks++; if (!ok || n + 15 != PERIOD || grant_id !== 2'd3) begin errors++;
            $display("FAIL ptr_req3_wins got id %0d spacing %0d want 3 %0d",
                     grant_id, n + 15, PERIOD); end
        req_valid = 4'b0010;
        wait_send(PERIOD + 4, n, ok);
        checks++; if (!ok || n != PERIOD || grant_id !== 2'd1) begin errors++;
            $display("FAIL ptr_req1_next got id %0d spacing %0d want 1 %0d",
                     grant_id, n, PERIOD); end
        req_valid = '0;
    endtask

    task automatic test_random();
        int n, ptr, w;
        bit ok;
        do_reset();
        ptr       = NREQ - 1;
        req_data  = $urandom;
        req_valid = 4'($urandom_range(1, 15));
        for (int f = 0; f < 12; f++) begin
            wait_send((f == 0) ? 4 : PERIOD, n, ok);
            w = rr_pick(ptr, req_valid);
            checks++; if (!ok || (f > 0 && n + 6 != PERIOD)) begin errors++;
                $display("FAIL rand_spacing frame %0d got %0d want %0d", f, n + 6, PERIOD); end
            checks++; if (grant_id !== 2'(w) || tx_data !== lane(req_data, w)
                          || req_ready !== 4'(1 << w)) begin errors++;
                $display("FAIL rand_grant frame %0d got id %0d data %h rdy %b want %0d %h",
                         f, grant_id, tx_data, req_ready, w, lane(req_data, w)); end
            ptr = w;
            // Mid-frame glitches must be ignored; the pattern held at idle decides.
            tick();
            req_valid = 4'($urandom);
            req_data  = $urandom;
            for (int i = 0; i < 5; i++) tick();
            req_valid = 4'($urandom_range(1, 15));
            req_data  = $urandom;
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_single_req2();
        test_reset_mid_frame();
        test_pointer_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
